uart_tx_buffer: RTL and testbench

- Byte FIFO plus sequencer directly upstream of the UART transmitter.
- Accepts bytes from the debug-module side through a write strobe.
- Hands them to the transmitter one at a time: registered start pulse with stable data, then waits for the transmitter's done pulse before issuing the next byte.
- Decouples bursty debug-response traffic from the slow serial line.

---
 rtl/uart_tx_buffer.sv | 108 ++++++++++
 tb/tb_uart_tx_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO and start/done sequencer in front of a UART transmitter.
// Optional sticky overflow flag (OVF_O / OVF_CLR_I) when UART_TX_BUFFER_OVF_EN is defined.
module uart_tx_buffer #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             CLK_I,
   input  logic             RST_NI,
   input  logic             WE_I,
   input  logic [WIDTH-1:0] DATA_I,
   input  logic             FLUSH_I,
   output logic             FULL_O,
   output logic             EMPTY_O,
   output logic             BUSY_O,
   output logic             TX_START_O,
   output logic [WIDTH-1:0] TX_DATA_O,
`ifdef UART_TX_BUFFER_OVF_EN
   output logic             OVF_O,
   input  logic             OVF_CLR_I,
`endif
   input  logic             TX_DONE_I
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic {ST_IDLE, ST_WAIT_DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_en, pop;

   assign FULL_O  = (count == CW'(DEPTH));
   assign EMPTY_O = (count == '0);
   assign BUSY_O  = (count != '0) | (state == ST_WAIT_DONE);

   // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
   assign wr_en = WE_I & ~FULL_O & ~FLUSH_I;

   // Next-state decode; the pop is tied to leaving ST_IDLE.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!EMPTY_O && !FLUSH_I) begin
               pop        = 1'b1;
               state_next = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (TX_DONE_I) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Pointer and occupancy bookkeeping; flush clears everything but the frame in flight.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI || FLUSH_I) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy is tracked by count.
   always_ff @(posedge CLK_I) begin
      if (wr_en) mem[wr_ptr] <= DATA_I;
   end

   // Transmitter handshake: one-cycle start, data held until the next start.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI) begin
         TX_START_O <= 1'b0;
         TX_DATA_O  <= '0;
      end else begin
         TX_START_O <= pop;
         if (pop) TX_DATA_O <= mem[rd_ptr];
      end
   end

`ifdef UART_TX_BUFFER_OVF_EN
   // Sticky overflow flag; a new overflow beats a simultaneous clear.
   always_ff @(posedge CLK_I) begin
      if (!RST_NI)               OVF_O <= 1'b0;
      else if (WE_I && FULL_O)   OVF_O <= 1'b1;
      else if (OVF_CLR_I)        OVF_O <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: scoreboard queue of expected bytes,
// compared whenever the DUT issues a start pulse.
module tb_uart_tx_buffer;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic             CLK_I = 1'b0;
   logic             RST_NI, WE_I, FLUSH_I, TX_DONE_I;
   logic [WIDTH-1:0] DATA_I;
   logic             FULL_O, EMPTY_O, BUSY_O, TX_START_O;
   logic [WIDTH-1:0] TX_DATA_O;
`ifdef UART_TX_BUFFER_OVF_EN
   logic             OVF_O, OVF_CLR_I;
`endif

   uart_tx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .CLK_I      (CLK_I),
      .RST_NI     (RST_NI),
      .WE_I       (WE_I),
      .DATA_I     (DATA_I),
      .FLUSH_I    (FLUSH_I),
      .FULL_O     (FULL_O),
      .EMPTY_O    (EMPTY_O),
      .BUSY_O     (BUSY_O),
      .TX_START_O (TX_START_O),
      .TX_DATA_O  (TX_DATA_O),
`ifdef UART_TX_BUFFER_OVF_EN
      .OVF_O      (OVF_O),
      .OVF_CLR_I  (OVF_CLR_I),
`endif
      .TX_DONE_I  (TX_DONE_I)
   );

   always #5 CLK_I = ~CLK_I;

   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               n_starts = 0;
   int               start_cyc = 0;
   int               wr_cyc   = 0;
   int               done_cyc = 0;
   logic             prev_start = 1'b0;
   logic [WIDTH-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge CLK_I) cyc <= cyc + 1;

   // Start-pulse monitor, sampled shortly after each active edge.
   always @(posedge CLK_I) begin
      #2;
      if (TX_START_O === 1'b1) begin
         n_starts++;
         start_cyc = cyc;
         if (prev_start) check("start_twice", TX_START_O, 0);
         if (exp_q.size() == 0) check("spurious_start", TX_START_O, 0);
         else                   check("tx_data", TX_DATA_O, exp_q.pop_front());
      end
      prev_start = (TX_START_O === 1'b1);
   end

   task automatic write_byte(input logic [WIDTH-1:0] b, input bit expect_sent);
      WE_I   = 1'b1;
      DATA_I = b;
      if (expect_sent) exp_q.push_back(b);
      @(negedge CLK_I);
      WE_I   = 1'b0;
      wr_cyc = cyc;
   endtask

   task automatic wait_starts(input int target, input int max_cyc);
      int i;
      i = 0;
      while (n_starts < target && i < max_cyc) begin
         @(negedge CLK_I);
         i++;
      end
      check("start_seen", n_starts, target);
   endtask

   task automatic done_pulse();
      TX_DONE_I = 1'b1;
      @(negedge CLK_I);
      TX_DONE_I = 1'b0;
      done_cyc  = cyc;
   endtask

   // Returns n frames one cycle-apart done, expecting a start 1 cycle after each done.
   task automatic drain(input int n);
      int target;
      for (int i = 0; i < n; i++) begin
         target = n_starts + 1;
         done_pulse();
         wait_starts(target, 10);
         check("done_to_start", start_cyc - done_cyc, 1);
      end
      done_pulse();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_empty"}, EMPTY_O, 1);
      check({tag, "_full"},  FULL_O, 0);
      check({tag, "_busy"},  BUSY_O, 0);
      check({tag, "_start"}, TX_START_O, 0);
      check({tag, "_data"},  TX_DATA_O, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      RST_NI = 1'b0; WE_I = 1'b0; FLUSH_I = 1'b0; TX_DONE_I = 1'b0; DATA_I = '0;
`ifdef UART_TX_BUFFER_OVF_EN
      OVF_CLR_I = 1'b0;
`endif
      repeat (3) @(negedge CLK_I);
      check_reset_outputs("rst");
      RST_NI = 1'b1;
      @(negedge CLK_I);

      // Single byte: start one edge after the write edge, no repeat.
      base = n_starts;
      write_byte(8'hA5, 1);
      check("empty_after_wr", EMPTY_O, 0);
      wait_starts(base + 1, 10);
      check("single_latency", start_cyc - wr_cyc, 1);
      repeat (10) @(negedge CLK_I);
      check("no_start_before_done", n_starts, base + 1);
      check("data_stable", TX_DATA_O, 8'hA5);
      check("busy_in_flight", BUSY_O, 1);
      done_pulse();
      repeat (10) @(negedge CLK_I);
      check("no_start_after_done", n_starts, base + 1);
      check("busy_idle", BUSY_O, 0);

      // Three back-to-back bytes, done 20 cycles after each start.
      base = n_starts;
      for (int i = 1; i <= 3; i++) write_byte(WIDTH'(i), 1);
      for (int i = 0; i < 3; i++) begin
         wait_starts(base + 1 + i, 40);
         if (i > 0) check("b2b_gap", start_cyc - done_cyc, 1);
         repeat (20) @(negedge CLK_I);
         done_pulse();
      end
      @(negedge CLK_I);
      check("b2b_busy_low", BUSY_O, 0);
      check("b2b_empty", EMPTY_O, 1);

      // Fill: 17 bytes with done held, then a dropped overflow write.
      base = n_starts;
      for (int i = 0; i < 17; i++) write_byte(WIDTH'(8'h10 + i), 1);
      check("fill_full", FULL_O, 1);
      check("fill_one_start", n_starts, base + 1);
      write_byte(8'h21, 0);
      check("fill_still_full", FULL_O, 1);
      drain(16);
      repeat (3) @(negedge CLK_I);
      check("fill_empty", EMPTY_O, 1);
      check("fill_busy_low", BUSY_O, 0);
      check("fill_q_drained", exp_q.size(), 0);

      // Flush during a frame with a concurrent write.
      base = n_starts;
      write_byte(8'h31, 1);
      for (int i = 2; i <= 5; i++) write_byte(WIDTH'(8'h30 + i), 0);
      wait_starts(base + 1, 5);
      FLUSH_I = 1'b1; WE_I = 1'b1; DATA_I = 8'h77;
      @(negedge CLK_I);
      FLUSH_I = 1'b0; WE_I = 1'b0;
      check("flush_empty", EMPTY_O, 1);
      check("flush_busy_wait", BUSY_O, 1);
      done_pulse();
      repeat (10) @(negedge CLK_I);
      check("flush_no_start", n_starts, base + 1);
      check("flush_busy_low", BUSY_O, 0);

      // Reset mid-frame with 4 bytes queued.
      base = n_starts;
      write_byte(8'h41, 1);
      for (int i = 2; i <= 5; i++) write_byte(WIDTH'(8'h40 + i), 0);
      wait_starts(base + 1, 5);
      RST_NI = 1'b0;
      @(negedge CLK_I);
      RST_NI = 1'b1;
      check_reset_outputs("midrst");
      done_pulse();
      repeat (10) @(negedge CLK_I);
      check("midrst_no_start", n_starts, base + 1);
      write_byte(8'h5A, 1);
      wait_starts(base + 2, 10);
      check("midrst_latency", start_cyc - wr_cyc, 1);
      done_pulse();
      repeat (3) @(negedge CLK_I);

`ifdef UART_TX_BUFFER_OVF_EN
      // Sticky overflow flag.
      check("ovf_reset", OVF_O, 0);
      for (int i = 0; i < 17; i++) write_byte(WIDTH'(8'h80 + i), 1);
      check("ovf_full", FULL_O, 1);
      check("ovf_not_yet", OVF_O, 0);
      write_byte(8'hFF, 0);
      check("ovf_set", OVF_O, 1);
      repeat (3) @(negedge CLK_I);
      check("ovf_sticky", OVF_O, 1);
      OVF_CLR_I = 1'b1;
      @(negedge CLK_I);
      OVF_CLR_I = 1'b0;
      check("ovf_clear", OVF_O, 0);
      OVF_CLR_I = 1'b1;
      write_byte(8'hFF, 0);
      OVF_CLR_I = 1'b0;
      check("ovf_set_wins", OVF_O, 1);
      OVF_CLR_I = 1'b1;
      @(negedge CLK_I);
      OVF_CLR_I = 1'b0;
      drain(16);
      repeat (3) @(negedge CLK_I);
      check("ovf_drained", exp_q.size(), 0);
`endif

      check("final_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
